mem_port_arbiter: RTL and testbench

Shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch port and its MEM-stage data port. It grants one requester at a time and sequences a ready-handshaked memory transaction, with a timeout that flags a hung bus. It returns read data and per-port stall signals, which feed the PC register and pipeline-register stall inputs. It sits between the IF/MEM stages and the external memory, in place of separate IMEM/DMEM.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_timeout_ctr.sv | 36 +++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified I/D memory port arbiter: the FSM state
// encoding and the default timeout depth and error read-data value.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    localparam int          DEF_TIMEOUT  = 16;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_timeout_ctr
// Counts busy cycles spent waiting on the memory. o_expired is high while the
// count sits at TIMEOUT-1, i.e. in the TIMEOUT-th busy cycle without ready.
//   i_clk      system clock
//   i_reset    asynchronous active-low reset
//   i_clr      synchronous clear (wins over i_en)
//   i_en       count enable
//   o_expired  count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module mem_timeout_ctr
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)  r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and the
// MEM-stage data port (DM). Data has fixed priority. Each access is a
// mem_req/mem_ready handshake with a timeout that returns ERR_DATA and sets a
// sticky bus_err.
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_if_req/addr/flush       fetch request (held until o_if_valid), flush
//   o_if_rdata/valid/stall    fetched word, completion pulse, stall
//   i_dm_rd/wr/addr/wdata     data request (held until o_dm_valid)
//   o_dm_rdata/valid/stall    load data, completion pulse, stall
//   o_mem_req/we/addr/wdata   memory request, held until ready/timeout
//   i_mem_ready, i_mem_rdata  memory completion and read data
//   o_bus_err                 sticky timeout / illegal-access flag
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = DEF_TIMEOUT,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
)(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    output logic              o_if_stall,
    input  logic              i_dm_rd,
    input  logic              i_dm_wr,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_valid,
    output logic              o_dm_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_bus_err
);

    arb_state_e        r_state;
    logic              r_flush_pending;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
    logic              r_if_valid, r_dm_valid;
    logic              r_bus_err;

    logic              w_dm_any, w_dm_elig, w_if_elig;
    logic              w_busy, w_expired, w_done, w_tmo;
    logic [DATA_W-1:0] w_rd_data;

    // A port in its valid cycle still has its request up; masking it here
    // keeps the same request from being issued twice.
    assign w_dm_any  = i_dm_rd | i_dm_wr;
    assign w_dm_elig = w_dm_any & ~r_dm_valid;
    assign w_if_elig = i_if_req & ~r_if_valid;

    assign w_busy    = (r_state != IDLE);
    // mem_ready wins over an expiry in the same cycle, so w_tmo needs ~ready.
    assign w_done    = w_busy & (i_mem_ready | w_expired);
    assign w_tmo     = w_busy & ~i_mem_ready & w_expired;
    assign w_rd_data = i_mem_ready ? i_mem_rdata : ERR_DATA;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (~w_busy | w_done),
        .i_en      (w_busy & ~i_mem_ready),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= IDLE;
            r_flush_pending <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_if_rdata      <= '0;
            r_dm_rdata      <= '0;
            r_if_valid      <= 1'b0;
            r_dm_valid      <= 1'b0;
            r_bus_err       <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_dm_elig) begin
                        r_mem_req   <= 1'b1;
                        // rd&wr together is illegal: perform the write, flag it
                        r_mem_we    <= i_dm_wr;
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
                        r_state     <= DM_BUSY;
                        if (i_dm_rd & i_dm_wr) r_bus_err <= 1'b1;
                    end else if (w_if_elig) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= i_if_addr;
                        r_state    <= IF_BUSY;
                    end
                end
                IF_BUSY: begin
                    if (w_done) begin
                        r_mem_req       <= 1'b0;
                        r_state         <= IDLE;
                        r_flush_pending <= 1'b0;
                        // A flush seen at any point of the access, including
                        // its last cycle, drops the fetched word.
                        if (!(r_flush_pending | i_if_flush)) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= w_rd_data;
                        end
                        if (w_tmo) r_bus_err <= 1'b1;
                    end else if (i_if_flush) begin
                        r_flush_pending <= 1'b1;
                    end
                end
                DM_BUSY: begin
                    if (w_done) begin
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_state    <= IDLE;
                        r_dm_valid <= 1'b1;
                        if (!r_mem_we) r_dm_rdata <= w_rd_data;
                        if (w_tmo) r_bus_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_valid  = r_dm_valid;
    assign o_bus_err   = r_bus_err;
    assign o_if_stall  = i_if_req & ~r_if_valid;
    assign o_dm_stall  = w_dm_any & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scenario tasks drive the two requester ports; a small memory responder
// answers mem_req after mem_lat wait cycles (mem_lat<0: never). Expected read
// data is queued when a request is driven and popped when its valid pulses.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk, rst_n;
    logic        if_req, if_flush, dm_rd, dm_wr, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          dm;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int          mem_lat  = -1;
    logic [31:0] mem_data = '0;
    logic [31:0] if_last  = '0;
    logic [31:0] dm_last  = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_rdata(if_rdata), .o_if_valid(if_valid), .o_if_stall(if_stall),
        .i_dm_rd(dm_rd), .i_dm_wr(dm_wr), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_rdata(dm_rdata), .o_dm_valid(dm_valid), .o_dm_stall(dm_stall),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: ready after mem_lat wait cycles of a held mem_req.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && mem_lat >= 0 && wcnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_data;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = '0;
            end
            wcnt = mem_req ? wcnt + 1 : 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_valid(input bit dm, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dm ? dm_valid : if_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit   seen;
        exp_t e;
        rst_n = 1'b0; if_req = 0; if_flush = 0; dm_rd = 0; dm_wr = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_lat = -1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, dm_rdata, dm_valid, bus_err} !== '0)
            begin errors++; $display("FAIL reset_outputs: got req=%b we=%b addr=%h err=%b required all zero", mem_req, mem_we, mem_addr, bus_err); end
        rst_n = 1'b1;
        @(negedge clk);                          // cycle 0
        dm_rd = 1'b1; dm_addr = 32'h40;
        @(negedge clk);                          // cycle 1
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40)
            begin errors++; $display("FAIL reset_pre_issue: got req=%b addr=%h required 1 00000040", mem_req, mem_addr); end
        @(negedge clk);                          // cycle 2
        @(posedge clk); #2;                      // cycle 3
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0)
            begin errors++; $display("FAIL reset_midflight_req: got %b required 0", mem_req); end
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, dm_rdata, dm_valid, bus_err} !== '0)
            begin errors++; $display("FAIL reset_midflight_outputs: got addr=%h err=%b required all zero", mem_addr, bus_err); end
        dm_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_lat = 0; mem_data = 32'h0000_0013;
        if_req = 1'b1; if_addr = 32'h30;
        sb.push_back('{1'b0, 32'h0000_0013});
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h30)
            begin errors++; $display("FAIL reset_regrant: got req=%b we=%b addr=%h required 1 0 00000030", mem_req, mem_we, mem_addr); end
        wait_valid(1'b0, 5, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_regrant_valid: got no if_valid required pulse"); end
        else begin
            e = sb.pop_front();
            checks++;
            if (if_rdata !== e.data)
                begin errors++; $display("FAIL reset_regrant_data: got %h required %h", if_rdata, e.data); end
            if_last = e.data;
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_fetch;
        exp_t e;
        mem_lat = 0; mem_data = 32'h2010_000C;
        if_req = 1'b1; if_addr = 32'h08;         // cycle 0
        sb.push_back('{1'b0, 32'h2010_000C});
        #1;
        checks++;
        if (if_stall !== 1'b1) begin errors++; $display("FAIL zw_stall_c0: got %b required 1", if_stall); end
        @(negedge clk);                          // cycle 1
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h08 || if_valid !== 1'b0)
            begin errors++; $display("FAIL zw_issue: got req=%b addr=%h valid=%b required 1 00000008 0", mem_req, mem_addr, if_valid); end
        @(negedge clk);                          // cycle 2
        checks++;
        if (if_valid !== 1'b1 || if_stall !== 1'b0)
            begin errors++; $display("FAIL zw_valid: got valid=%b stall=%b required 1 0", if_valid, if_stall); end
        e = sb.pop_front();
        checks++;
        if (if_rdata !== e.data) begin errors++; $display("FAIL zw_data: got %h required %h", if_rdata, e.data); end
        if_last = e.data;
        if_req = 1'b0;
        @(negedge clk);                          // cycle 3
        checks++;
        if (if_valid !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL zw_pulse_width: got valid=%b req=%b required 0 0", if_valid, mem_req); end
    endtask

    task automatic test_contention;
        exp_t e;
        mem_lat = 0; mem_data = 32'h00A0_0093;
        if_req = 1'b1; if_addr = 32'h0C;         // cycle 0
        dm_wr = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678;
        sb.push_back('{1'b0, 32'h00A0_0093});
        @(negedge clk);                          // cycle 1
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'h1234_5678)
            begin errors++; $display("FAIL cont_write_first: got req=%b we=%b addr=%h wdata=%h required 1 1 00000080 12345678", mem_req, mem_we, mem_addr, mem_wdata); end
        @(negedge clk);                          // cycle 2
        checks++;
        if (dm_valid !== 1'b1 || if_valid !== 1'b0)
            begin errors++; $display("FAIL cont_dm_valid: got dm=%b if=%b required 1 0", dm_valid, if_valid); end
        checks++;
        if (dm_rdata !== dm_last)
            begin errors++; $display("FAIL cont_write_rdata: got %h required %h", dm_rdata, dm_last); end
        dm_wr = 1'b0;
        @(negedge clk);                          // cycle 3
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0C)
            begin errors++; $display("FAIL cont_fetch_grant: got req=%b we=%b addr=%h required 1 0 0000000c", mem_req, mem_we, mem_addr); end
        @(negedge clk);                          // cycle 4
        checks++;
        if (if_valid !== 1'b1) begin errors++; $display("FAIL cont_if_valid: got %b required 1", if_valid); end
        e = sb.pop_front();
        checks++;
        if (if_rdata !== e.data) begin errors++; $display("FAIL cont_if_data: got %h required %h", if_rdata, e.data); end
        if_last = e.data;
        if_req = 1'b0;
        @(negedge clk);
    endtask

    // Ready lands in the same cycle the counter expires: ready must win.
    task automatic test_wait_states;
        exp_t e;
        mem_lat = 3; mem_data = 32'hCAFE_F00D;
        dm_rd = 1'b1; dm_addr = 32'h44;          // cycle 0
        sb.push_back('{1'b1, 32'hCAFE_F00D});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h44 || dm_valid !== 1'b0 || dm_stall !== 1'b1)
                begin errors++; $display("FAIL ws_hold_c%0d: got req=%b addr=%h valid=%b stall=%b required 1 00000044 0 1", k, mem_req, mem_addr, dm_valid, dm_stall); end
        end
        @(negedge clk);                          // cycle 5
        checks++;
        if (dm_valid !== 1'b1 || dm_stall !== 1'b0 || bus_err !== 1'b0)
            begin errors++; $display("FAIL ws_done: got valid=%b stall=%b err=%b required 1 0 0", dm_valid, dm_stall, bus_err); end
        e = sb.pop_front();
        checks++;
        if (dm_rdata !== e.data) begin errors++; $display("FAIL ws_data: got %h required %h", dm_rdata, e.data); end
        dm_last = e.data;
        dm_rd = 1'b0;
        @(negedge clk);                          // cycle 6
        checks++;
        if (dm_valid !== 1'b0) begin errors++; $display("FAIL ws_pulse_width: got %b required 0", dm_valid); end
    endtask

    task automatic test_flush;
        bit   seen;
        exp_t e;
        mem_lat = 2; mem_data = 32'h1111_1111;
        if_req = 1'b1; if_addr = 32'h10;         // cycle 0
        @(negedge clk);                          // cycle 1
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10)
            begin errors++; $display("FAIL fl_issue: got req=%b addr=%h required 1 00000010", mem_req, mem_addr); end
        if_flush = 1'b1; if_addr = 32'h20;
        @(negedge clk);                          // cycle 2
        if_flush = 1'b0;
        checks++;
        if (mem_addr !== 32'h10) begin errors++; $display("FAIL fl_addr_held: got %h required 00000010", mem_addr); end
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b0 || if_rdata !== if_last)
                begin errors++; $display("FAIL fl_suppress_c%0d: got valid=%b rdata=%h required 0 %h", k, if_valid, if_rdata, if_last); end
            if (k == 4) begin
                mem_data = 32'h2222_2222;
                sb.push_back('{1'b0, 32'h2222_2222});
            end
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h20)
            begin errors++; $display("FAIL fl_reissue: got req=%b addr=%h required 1 00000020", mem_req, mem_addr); end
        wait_valid(1'b0, 8, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL fl_refetch_valid: got no if_valid required pulse"); end
        else begin
            e = sb.pop_front();
            checks++;
            if (if_rdata !== e.data) begin errors++; $display("FAIL fl_refetch_data: got %h required %h", if_rdata, e.data); end
            if_last = e.data;
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        exp_t e;
        mem_lat = -1;
        dm_rd = 1'b1; dm_addr = 32'h48;          // cycle 0
        sb.push_back('{1'b1, ERR});
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || dm_valid !== 1'b0 || bus_err !== 1'b0)
                begin errors++; $display("FAIL to_wait_c%0d: got req=%b valid=%b err=%b required 1 0 0", k, mem_req, dm_valid, bus_err); end
        end
        @(negedge clk);                          // cycle TO+1
        checks++;
        if (dm_valid !== 1'b1 || bus_err !== 1'b1 || mem_req !== 1'b0)
            begin errors++; $display("FAIL to_expire: got valid=%b err=%b req=%b required 1 1 0", dm_valid, bus_err, mem_req); end
        e = sb.pop_front();
        checks++;
        if (dm_rdata !== e.data) begin errors++; $display("FAIL to_err_data: got %h required %h", dm_rdata, e.data); end
        dm_rd = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus_err !== 1'b1 || dm_valid !== 1'b0)
                begin errors++; $display("FAIL to_sticky_%0d: got err=%b valid=%b required 1 0", k, bus_err, dm_valid); end
        end
    endtask

    task automatic test_illegal_access;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL ill_reset_clears_err: got %b required 0", bus_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_lat = 0;
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 32'h84; dm_wdata = 32'h55AA_55AA;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h55AA_55AA || bus_err !== 1'b1)
            begin errors++; $display("FAIL ill_write: got req=%b we=%b wdata=%h err=%b required 1 1 55aa55aa 1", mem_req, mem_we, mem_wdata, bus_err); end
        @(negedge clk);
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'h0)
            begin errors++; $display("FAIL ill_done: got valid=%b rdata=%h required 1 00000000", dm_valid, dm_rdata); end
        dm_rd = 1'b0; dm_wr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_contention();
        test_wait_states();
        test_flush();
        test_timeout();
        test_illegal_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
